// File: rtl/sparse_chunk_encoder_pkg.sv
// ============================================================================
// Module  : sparse_chunk_encoder_pkg
// Brief   : Shared sizes, beat typedefs and FSM encodings for the encoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package sparse_chunk_encoder_pkg;

    localparam int BUS_SIZE_DEF   = 16;
    localparam int MEM_SIZE_DEF   = 128;
    localparam int WR_CYC_NUM_DEF = MEM_SIZE_DEF / BUS_SIZE_DEF;

    typedef logic [BUS_SIZE_DEF-1:0][7:0] beat_data_t;
    typedef logic [BUS_SIZE_DEF-1:0]      smap_t;

    localparam logic [0:0] c_FILL  = 1'b0;
    localparam logic [0:0] c_DRAIN = 1'b1;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sparse_chunk_encoder_if.sv
// ============================================================================
// Module  : sparse_chunk_encoder_if
// Brief   : Dense input beat bus and sparse write-beat bus of the encoder.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

interface sparse_chunk_encoder_if
    import sparse_chunk_encoder_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) ();
    localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int CNT_W      = cnt_w(WR_CYC_NUM);
    localparam int NZ_W       = $clog2(MEM_SIZE + 1);

    logic [BUS_SIZE-1:0][7:0] dense_data_i;
    logic                     dense_valid_i;
    logic                     dense_last_i;
    logic                     dense_ready_o;
    logic [BUS_SIZE-1:0]      sparsemap_o;
    logic [BUS_SIZE-1:0][7:0] nonzero_data_o;
    logic                     wr_valid_o;
    logic [CNT_W-1:0]         wr_count_o;
    logic                     wr_ready_i;
    logic [NZ_W-1:0]          nz_count_o;
    logic                     chunk_done_o;

    modport slave (
        input  dense_data_i, dense_valid_i, dense_last_i, wr_ready_i,
        output dense_ready_o, sparsemap_o, nonzero_data_o, wr_valid_o,
               wr_count_o, nz_count_o, chunk_done_o
    );

    modport master (
        output dense_data_i, dense_valid_i, dense_last_i, wr_ready_i,
        input  dense_ready_o, sparsemap_o, nonzero_data_o, wr_valid_o,
               wr_count_o, nz_count_o, chunk_done_o
    );

endinterface

`default_nettype wire

// File: rtl/sparse_chunk_encoder_compactor.sv
// ============================================================================
// Module  : sparse_beat_compactor
// Brief   : Packs the nonzero bytes of one beat to the front, ascending order.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sparse_beat_compactor
    import sparse_chunk_encoder_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF
) (
    input  logic [BUS_SIZE-1:0][7:0]          i_data,
    output logic [BUS_SIZE-1:0][7:0]          o_compact,
    output logic [BUS_SIZE-1:0]               o_map,
    output logic [$clog2(BUS_SIZE+1)-1:0]     o_count
);
    localparam int C_K_W = $clog2(BUS_SIZE + 1);

    logic [C_K_W-1:0] w_prefix [BUS_SIZE];
    logic [C_K_W-1:0] w_acc;

    generate
        for (genvar g = 0; g < BUS_SIZE; g++) begin : g_map
            assign o_map[g] = |i_data[g];
        end
    endgenerate

    // Exclusive prefix sum gives each nonzero byte its packed slot.
    always_comb begin
        w_acc = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            w_prefix[i] = w_acc;
            w_acc       = w_acc + C_K_W'(o_map[i]);
        end
        o_count = w_acc;
    end

    always_comb begin
        o_compact = '0;
        for (int i = 0; i < BUS_SIZE; i++) begin
            for (int j = 0; j < BUS_SIZE; j++) begin
                if (o_map[j] && (w_prefix[j] == C_K_W'(i))) begin
                    o_compact[i] = i_data[j];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sparse_chunk_encoder.sv
// ============================================================================
// Module  : sparse_chunk_encoder
// Brief   : Store-and-forward dense-to-sparse chunk encoder (fill, then drain).
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sparse_chunk_encoder
    import sparse_chunk_encoder_pkg::*;
#(
    parameter int BUS_SIZE = BUS_SIZE_DEF,
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    sparse_chunk_encoder_if.slave   bus
);
    localparam int WR_CYC_NUM = MEM_SIZE / BUS_SIZE;
    localparam int C_CNT_W    = cnt_w(WR_CYC_NUM);
    localparam int C_PTR_W    = $clog2(MEM_SIZE + 1);
    localparam int C_ADDR_W   = cnt_w(MEM_SIZE);
    localparam int C_K_W      = $clog2(BUS_SIZE + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(WR_CYC_NUM - 1);

    logic [0:0]               r_state;
    logic [0:0]               w_state_nxt;
    logic                     r_rdy_en;
    logic [C_CNT_W-1:0]       r_fill_cnt;
    logic [C_CNT_W-1:0]       r_wr_cnt;
    logic [C_PTR_W-1:0]       r_nz_ptr;
    logic [C_PTR_W-1:0]       r_nz_count;
    logic [BUS_SIZE-1:0]      r_smap [WR_CYC_NUM];
    logic [WR_CYC_NUM-1:0]    r_smap_vld;
    logic [7:0]               r_data [MEM_SIZE];
    logic [MEM_SIZE-1:0]      r_data_vld;

    logic [BUS_SIZE-1:0][7:0] w_compact;
    logic [BUS_SIZE-1:0]      w_nz_map;
    logic [C_K_W-1:0]         w_k;
    logic                     w_in_fill;
    logic                     w_in_drain;
    logic                     w_accept;
    logic                     w_fill_end;
    logic                     w_wr_hs;
    logic                     w_drain_end;
    logic [C_ADDR_W-1:0]      w_wr_idx [BUS_SIZE];
    logic [C_ADDR_W-1:0]      w_rd_idx [BUS_SIZE];

    sparse_beat_compactor #(.BUS_SIZE(BUS_SIZE)) u_compactor (
        .i_data    (bus.dense_data_i),
        .o_compact (w_compact),
        .o_map     (w_nz_map),
        .o_count   (w_k)
    );

    assign w_in_fill   = (r_state == c_FILL);
    assign w_in_drain  = (r_state == c_DRAIN);
    assign w_accept    = w_in_fill && r_rdy_en && bus.dense_valid_i;
    assign w_fill_end  = w_accept && (bus.dense_last_i || (r_fill_cnt == C_LAST_BEAT));
    assign w_wr_hs     = w_in_drain && bus.wr_ready_i;
    assign w_drain_end = w_wr_hs && (r_wr_cnt == C_LAST_BEAT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= c_FILL;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_FILL:  if (w_fill_end)  w_state_nxt = c_DRAIN;
            c_DRAIN: if (w_drain_end) w_state_nxt = c_FILL;
            default: w_state_nxt = c_FILL;
        endcase
    end

    // Every drain output is gated by the state so an async reset zeroes them at once.
    always_comb begin
        bus.dense_ready_o = w_in_fill && r_rdy_en;
        bus.wr_valid_o    = w_in_drain;
        bus.chunk_done_o  = w_drain_end;
        bus.wr_count_o    = w_in_drain ? r_wr_cnt   : '0;
        bus.nz_count_o    = w_in_drain ? r_nz_count : '0;
        bus.sparsemap_o   = (w_in_drain && r_smap_vld[r_wr_cnt]) ? r_smap[r_wr_cnt] : '0;
        for (int j = 0; j < BUS_SIZE; j++) begin
            bus.nonzero_data_o[j] = (w_in_drain && r_data_vld[w_rd_idx[j]] &&
                                     (C_PTR_W'(w_rd_idx[j]) < r_nz_count))
                                    ? r_data[w_rd_idx[j]] : 8'h00;
        end
    end

    always_comb begin
        for (int i = 0; i < BUS_SIZE; i++) begin
            w_wr_idx[i] = r_nz_ptr[C_ADDR_W-1:0] + C_ADDR_W'(i);
            w_rd_idx[i] = C_ADDR_W'(r_wr_cnt) * C_ADDR_W'(BUS_SIZE) + C_ADDR_W'(i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rdy_en <= 1'b0;
        else       r_rdy_en <= 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fill_cnt <= '0;
            r_nz_ptr   <= '0;
            r_nz_count <= '0;
            r_wr_cnt   <= '0;
        end else begin
            if (w_accept) begin
                if (w_fill_end) begin
                    r_fill_cnt <= '0;
                    r_nz_ptr   <= '0;
                    r_nz_count <= r_nz_ptr + C_PTR_W'(w_k);
                end else begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                    r_nz_ptr   <= r_nz_ptr + C_PTR_W'(w_k);
                end
            end
            if (w_wr_hs) begin
                r_wr_cnt <= w_drain_end ? '0 : r_wr_cnt + 1'b1;
            end
        end
    end

    // Payload arrays carry no reset; the valid flags alone decide what is visible.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_smap[r_fill_cnt] <= w_nz_map;
            for (int i = 0; i < BUS_SIZE; i++) begin
                if (C_K_W'(i) < w_k) r_data[w_wr_idx[i]] <= w_compact[i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_smap_vld <= '0;
            r_data_vld <= '0;
        end else if (w_drain_end) begin
            r_smap_vld <= '0;
            r_data_vld <= '0;
        end else if (w_accept) begin
            r_smap_vld[r_fill_cnt] <= 1'b1;
            for (int i = 0; i < BUS_SIZE; i++) begin
                if (C_K_W'(i) < w_k) r_data_vld[w_wr_idx[i]] <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire
